// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Holds the FSM state encoding and the default operand width.
package mult_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned CntWidth     = $clog2(DefaultWidth);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

endpackage

// File: rtl/shift_add_dp.sv
// Datapath for the shift-and-add multiplier.
// Holds the operand shift registers, the 2*WIDTH accumulator and its adder.
module shift_add_dp #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               b_rest_zero,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;

    // Accumulator value after the current iteration; also the final result on the last one.
    assign acc_next    = acc_q + (b_q[0] ? a_sh_q : '0);
    assign b_rest_zero = (b_q[WIDTH-1:1] == '0);

    always_comb begin
        a_sh_d = a_sh_q;
        b_d    = b_q;
        acc_d  = acc_q;
        if (load) begin
            a_sh_d = {{WIDTH{1'b0}}, a_in};
            b_d    = b_in;
            acc_d  = '0;
        end else if (step) begin
            a_sh_d = {a_sh_q[2*WIDTH-2:0], 1'b0};
            b_d    = {1'b0, b_q[WIDTH-1:1]};
            acc_d  = acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q <= '0;
            b_q    <= '0;
            acc_q  <= '0;
        end else begin
            a_sh_q <= a_sh_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier: FSM, iteration counter and result registers.
// Define SIGNED_MODE_EN to add the signed_op port and two's-complement support.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
`ifdef SIGNED_MODE_EN
    input  logic               signed_op,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               load, step, calc_last, b_rest_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_next, result;

`ifdef SIGNED_MODE_EN
    logic neg_q, neg_d;

    always_comb begin
        a_mag = a_in;
        b_mag = b_in;
        neg_d = neg_q;
        if (signed_op) begin
            // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
            if (a_in[WIDTH-1]) a_mag = -a_in;
            if (b_in[WIDTH-1]) b_mag = -b_in;
        end
        if (load) neg_d = signed_op & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
    end

    assign result = neg_q ? -acc_next : acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) neg_q <= 1'b0;
        else        neg_q <= neg_d;
    end
`else
    assign a_mag  = a_in;
    assign b_mag  = b_in;
    assign result = acc_next;
`endif

    assign calc_last = b_rest_zero || (cnt_q == CntW'(WIDTH - 1));

    shift_add_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .step       (step),
        .a_in       (a_mag),
        .b_in       (b_mag),
        .b_rest_zero(b_rest_zero),
        .acc_next   (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StCalc;
            StCalc:  if (calc_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
        load = (state_q == StIdle) && start;
        step = (state_q == StCalc);
    end

    always_comb begin
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        product_d = product_q;
        if (load) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (calc_last) begin
                done_d    = 1'b1;
                product_d = result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed self-checking bench for shift_add_mult at WIDTH=16.
// Signed vectors are exercised only when SIGNED_MODE_EN is defined.
module tb_shift_add_mult;

    localparam int unsigned W = 16;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
`ifdef SIGNED_MODE_EN
    logic           signed_op;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [2*W-1:0] last_product;

    shift_add_mult #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
`ifdef SIGNED_MODE_EN
        .signed_op(signed_op),
`endif
        .busy     (busy),
        .done     (done),
        .product  (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation and check latency, busy, done pulse, result and hold behaviour.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sop, input logic [2*W-1:0] exp_p, input int exp_k,
                          input logic glitch);
        int cycles;
        int extra;
        logic busy_dropped;
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
`ifdef SIGNED_MODE_EN
        signed_op = sop;
`endif
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq({tag, ".busy_accept"}, 64'(busy), 64'd1);
        check_eq({tag, ".prod_held"}, 64'(product), 64'(last_product));
        if (glitch) begin
            start = 1'b1;
            a_in  = 16'd9;
            b_in  = 16'd9;
        end
        cycles       = 0;
        busy_dropped = 1'b0;
        while (cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = 1'b0;
            if (!busy) busy_dropped = 1'b1;
            if (done) break;
        end
        check_eq({tag, ".latency"}, 64'(cycles), 64'(exp_k));
        check_eq({tag, ".busy_during"}, 64'(busy_dropped), 64'd0);
        check_eq({tag, ".product"}, 64'(product), 64'(exp_p));
        @(negedge clk);
        check_eq({tag, ".done_clear"}, 64'(done), 64'd0);
        check_eq({tag, ".idle"}, 64'(busy), 64'd0);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) extra++;
        end
        check_eq({tag, ".no_extra_done"}, 64'(extra), 64'd0);
        check_eq({tag, ".prod_stable"}, 64'(product), 64'(exp_p));
        last_product = exp_p;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
`ifdef SIGNED_MODE_EN
        signed_op = 1'b0;
`endif
        last_product = '0;
        repeat (3) @(negedge clk);
        check_eq("reset.busy", 64'(busy), 64'd0);
        check_eq("reset.done", 64'(done), 64'd0);
        check_eq("reset.product", 64'(product), 64'd0);
        rst_n = 1'b1;

        run_op("u3x5_glitch", 16'd3, 16'd5, 1'b0, 32'd15, 3, 1'b1);
        run_op("u1234x0", 16'h1234, 16'h0000, 1'b0, 32'h0, 1, 1'b0);
        run_op("uFFFFxFFFF", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 16, 1'b0);
        run_op("uABCDx1", 16'hABCD, 16'h0001, 1'b0, 32'h0000ABCD, 1, 1'b0);
        run_op("u0100x8000", 16'h0100, 16'h8000, 1'b0, 32'h00800000, 16, 1'b0);
        run_op("uFFFDx7", 16'hFFFD, 16'h0007, 1'b0, 32'h0006FFEB, 3, 1'b0);
`ifdef SIGNED_MODE_EN
        run_op("sm3x7", 16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, 3, 1'b0);
        run_op("s8000x8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000, 16, 1'b0);
        run_op("s5xm1", 16'h0005, 16'hFFFF, 1'b1, 32'hFFFFFFFB, 1, 1'b0);
        run_op("sm4xm6", 16'hFFFC, 16'hFFFA, 1'b1, 32'h00000018, 3, 1'b0);
`endif

        // Abort a long operation partway through CALC.
        @(negedge clk);
        start = 1'b1;
        a_in  = 16'hFFFF;
        b_in  = 16'hFFFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort.busy", 64'(busy), 64'd0);
        check_eq("abort.done", 64'(done), 64'd0);
        check_eq("abort.product", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_product = '0;
        run_op("post_reset6x7", 16'd6, 16'd7, 1'b0, 32'd42, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits, legal range 2..32.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 a_in  input  WIDTH  multiplicand; captured when start is accepted.
REQ-006 b_in  input  WIDTH  multiplier; captured when start is accepted.
REQ-007 signed_op  input  1  two's-complement operation select; present only with SIGNED_MODE_EN.
REQ-008 busy  output  1  high in every state other than IDLE.
REQ-009 done  output  1  registered; one-cycle pulse marking product valid.
REQ-010 product  output  2*WIDTH  registered result; held until the next result is written.

Function
REQ-011 States SHALL be IDLE, CALC and DONE; no other states are reachable.
REQ-012 IDLE SHALL move to CALC when start=1. At that edge it SHALL capture the operands, clear the accumulator and clear the iteration counter.
REQ-013 Each CALC cycle SHALL:
  - add the shifted multiplicand to the accumulator when the current multiplier LSB is 1;
  - shift the multiplicand left by 1 and the multiplier right by 1;
  - increment the iteration counter.
REQ-014 CALC SHALL move to DONE when the remaining multiplier after the shift is zero, or when the iteration counter reaches WIDTH-1 (early termination).
REQ-015 Number of CALC cycles k SHALL be max(1, msb_index(|b|)+1), with msb_index(0) treated as -1; therefore 1 <= k <= WIDTH.
REQ-016 On the CALC->DONE edge, the final result SHALL be written to product and done SHALL be set.
REQ-017 DONE SHALL return to IDLE after exactly one cycle; done SHALL clear on that edge.
REQ-018 If start is sampled at edge N, done and the new product SHALL be visible after edge N+k.
REQ-019 start SHALL be ignored while busy=1; operands and product SHALL be unaffected.
REQ-020 start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE.
REQ-021 The accumulator SHALL be 2*WIDTH bits wide; an unsigned product SHALL never overflow.
REQ-022 product SHALL keep its previous value from operation accept until the new result is written.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, product=0, accumulator=0, counter=0.
REQ-024 Reset during CALC or DONE SHALL abandon the operation with no partial product visible.
REQ-025 The first start after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-026 Macro SIGNED_MODE_EN SHALL compile in the signed_op port and signed support.
REQ-027 With SIGNED_MODE_EN and signed_op=1 at accept:
  - magnitudes of both operands SHALL be captured;
  - result sign = a_in[WIDTH-1] XOR b_in[WIDTH-1];
  - the 2*WIDTH result SHALL be negated on the DONE write when the sign is 1;
  - k SHALL be computed from |b|.
REQ-028 The magnitude of -2^(WIDTH-1) SHALL be handled as unsigned 2^(WIDTH-1), giving a correct result.
REQ-029 Without SIGNED_MODE_EN: no signed_op port, unsigned-only operation, no negation logic; otherwise identical timing.

Structure
REQ-030 Package mult_pkg SHALL hold:
  - the state enum type (IDLE/CALC/DONE);
  - the WIDTH default constant;
  - a constant for counter width, $clog2(WIDTH).
REQ-031 One sub-module, shift_add_dp, SHALL hold the operand shift registers, accumulator and adder. The FSM, counter and output registers SHALL stay in shift_add_mult.

Verification (WIDTH=16)
REQ-032 a=3, b=5, unsigned -> product=15, done single-cycle high after edge N+3, busy high edges N..N+3.
REQ-033 a=0x1234, b=0 -> product=0, done after edge N+1 (k=1).
REQ-034 a=0xFFFF, b=0xFFFF, unsigned -> product=0xFFFE0001, done after edge N+16.
REQ-035 SIGNED_MODE_EN, signed_op=1:
  - a=0xFFFD (-3), b=7 -> product=0xFFFFFFEB (-21), done after N+3;
  - a=0x8000, b=0x8000 -> product=0x40000000, done after N+16.
REQ-036 New start (a=9, b=9) pulsed during CALC of the REQ-032 operation -> ignored; product=15; no extra done pulse.
REQ-037 rst_n pulsed low mid-CALC -> busy/done/product=0 immediately; next start a=6, b=7 -> product=42, done after N+3.
